// File: rtl/i2s_stream_writer.sv
// i2s_stream_writer
// Single-clock I2S / left-justified transmitter with a stereo frame FIFO.
// Frames {left,right} are pushed from the DMA side and popped at each frame
// start. Each frame is serialised MSB-first as two SLOT_WIDTH-bit slots.
// Each slot holds SAMPLE_WIDTH sample bits followed by zero padding.
//
// Ports:
//   clk, rst           sole clock; synchronous active-low reset
//   enable             run the serialiser (0 = outputs held low, FIFO kept)
//   mode               0 = I2S (one-bit delay), 1 = left-justified
//   frame_valid/ready  push handshake; frame_left/frame_right sample data
//   fifo_count         occupied FIFO entries
//   starved            sticky underrun flag, cleared by starved_clear
//   i2s_bclk/lr/data   codec pins
//
// Build option: define I2S_STREAM_HOLD_LAST_EN to make an underrun frame
// repeat the last popped frame instead of sending zeros.
module i2s_stream_writer #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLK_DIV      = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            mode,
  input  logic                            frame_valid,
  output logic                            frame_ready,
  input  logic [SAMPLE_WIDTH-1:0]         frame_left,
  input  logic [SAMPLE_WIDTH-1:0]         frame_right,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            starved,
  input  logic                            starved_clear,
  output logic                            i2s_bclk,
  output logic                            i2s_lr,
  output logic                            i2s_data
);
  localparam int FW = 2*SLOT_WIDTH;
  localparam int EW = 2*SAMPLE_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int BW = $clog2(FW);
  localparam int DW = $clog2(2*CLK_DIV);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            frame_start;
  logic [DW-1:0]   div_cnt;
  logic [BW-1:0]   bit_cnt, bit_nxt;
  logic            div_rise, div_end, bit_last;
  logic [FW-1:0]   sh;
  logic            last_q;

  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop, underrun, fifo_empty;
  logic [EW-1:0]   rd_data;
  logic [FW-1:0]   pop_frame, under_frame, next_frame;

  // ---------------------------------------------------------------- FSM
  assign div_rise = (div_cnt == DW'(CLK_DIV-1));
  assign div_end  = (div_cnt == DW'(2*CLK_DIV-1));
  assign bit_last = (bit_cnt == BW'(FW-1));
  assign bit_nxt  = bit_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    case (state_q)
      IDLE: if (enable) begin
        state_d     = RUN;
        frame_start = 1'b1;
      end
      RUN: begin
        if (!enable)                  state_d     = IDLE;
        else if (div_end && bit_last) frame_start = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------- FIFO
  assign fifo_empty  = (count == '0);
  assign frame_ready = (count != CW'(FIFO_DEPTH));
  assign fifo_count  = count;
  assign push        = frame_valid && frame_ready;
  assign pop         = frame_start && !fifo_empty;
  assign underrun    = frame_start && fifo_empty;
  assign rd_data     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {frame_left, frame_right};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Place each sample at the top of its slot; padding falls out as zeros.
  assign pop_frame = (FW'(rd_data[EW-1:SAMPLE_WIDTH])  << (FW-SAMPLE_WIDTH)) |
                     (FW'(rd_data[SAMPLE_WIDTH-1:0])   << (SLOT_WIDTH-SAMPLE_WIDTH));

`ifdef I2S_STREAM_HOLD_LAST_EN
  logic [FW-1:0] hold_q;
  always_ff @(posedge clk) begin
    if (!rst)     hold_q <= '0;
    else if (pop) hold_q <= pop_frame;
  end
  assign under_frame = hold_q;
`else
  assign under_frame = '0;
`endif

  assign next_frame = pop ? pop_frame : under_frame;

  always_ff @(posedge clk) begin
    if (!rst)                            starved <= 1'b0;
    else if (underrun)                   starved <= 1'b1;
    else if (starved_clear)              starved <= 1'b0;
  end

  // ---------------------------------------------------------- Serialiser
  // sh always holds the not-yet-driven stream bits at its MSB. In I2S mode
  // position 0 carries last_q (final bit of the previous frame, 0 after
  // entering RUN), so the new frame is loaded unshifted.
  always_ff @(posedge clk) begin
    if (!rst || !enable) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      last_q   <= 1'b0;
      i2s_bclk <= 1'b0;
      i2s_lr   <= 1'b0;
      i2s_data <= 1'b0;
    end else if (frame_start) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      last_q   <= next_frame[0];
      i2s_bclk <= 1'b0;
      i2s_lr   <= 1'b0;
      if (mode) begin
        i2s_data <= next_frame[FW-1];
        sh       <= next_frame << 1;
      end else begin
        i2s_data <= last_q;
        sh       <= next_frame;
      end
    end else if (div_end) begin
      div_cnt  <= '0;
      bit_cnt  <= bit_nxt;
      i2s_bclk <= 1'b0;
      i2s_lr   <= (bit_nxt >= BW'(SLOT_WIDTH));
      i2s_data <= sh[FW-1];
      sh       <= sh << 1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      if (div_rise) i2s_bclk <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_stream_writer.sv
// Directed bench for i2s_stream_writer: SAMPLE 24, SLOT 32, FIFO 8, CLK_DIV 2.
module tb_i2s_stream_writer;
  logic        clk = 1'b0;
  logic        rst, enable, mode, frame_valid, starved_clear;
  logic [23:0] frame_left, frame_right;
  logic        frame_ready, starved, i2s_bclk, i2s_lr, i2s_data;
  logic [3:0]  fifo_count;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [63:0] LR_EXP = {32'h0000_0000, 32'hFFFF_FFFF};

  i2s_stream_writer #(
    .SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .FIFO_DEPTH(8), .CLK_DIV(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_left(frame_left), .frame_right(frame_right),
    .fifo_count(fifo_count), .starved(starved), .starved_clear(starved_clear),
    .i2s_bclk(i2s_bclk), .i2s_lr(i2s_lr), .i2s_data(i2s_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] fr(input logic [23:0] l, input logic [23:0] r);
    return {l, 8'h00, r, 8'h00};
  endfunction

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    @(negedge clk);
    frame_valid = 1'b1; frame_left = l; frame_right = r;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  // Records data and lr at the next 64 bclk rising edges.
  task automatic capture(output logic [63:0] d, output logic [63:0] l,
                         output int low, output bit ok);
    int n;
    logic prev;
    n = 0; low = 0; d = '0; l = '0; prev = i2s_bclk;
    for (int c = 0; c < 2000 && n < 64; c++) begin
      @(negedge clk);
      if (i2s_lr === 1'b0) low++;
      if (i2s_bclk === 1'b1 && prev === 1'b0) begin
        d[63-n] = i2s_data;
        l[63-n] = i2s_lr;
        n++;
      end
      prev = i2s_bclk;
    end
    ok = (n == 64);
  endtask

  task automatic test_reset;
    rst = 1'b0; enable = 1'b1; mode = 1'b1; frame_valid = 1'b1;
    frame_left = 24'hA5A5A5; frame_right = 24'h3C3C3C; starved_clear = 1'b0;
    repeat (6) @(negedge clk);
    n_total++; if (i2s_bclk !== 1'b0) $display("FAIL reset_bclk got %b want 0", i2s_bclk); else n_pass++;
    n_total++; if (i2s_lr !== 1'b0) $display("FAIL reset_lr got %b want 0", i2s_lr); else n_pass++;
    n_total++; if (i2s_data !== 1'b0) $display("FAIL reset_data got %b want 0", i2s_data); else n_pass++;
    n_total++; if (fifo_count !== 4'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else n_pass++;
    n_total++; if (frame_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", frame_ready); else n_pass++;
    n_total++; if (starved !== 1'b0) $display("FAIL reset_starved got %b want 0", starved); else n_pass++;
    frame_valid = 1'b0; enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_left_justified;
    logic [63:0] d, l; int low; bit ok;
    push(24'hA5A5A5, 24'h3C3C3C);
    n_total++; if (fifo_count !== 4'd1) $display("FAIL lj_count got %0d want 1", fifo_count); else n_pass++;
    mode = 1'b1; enable = 1'b1;
    capture(d, l, low, ok);
    n_total++; if (!ok) $display("FAIL lj_timeout got no frame want 64 bclk rises"); else n_pass++;
    n_total++; if (d !== fr(24'hA5A5A5, 24'h3C3C3C)) $display("FAIL lj_data got %h want %h", d, fr(24'hA5A5A5, 24'h3C3C3C)); else n_pass++;
    n_total++; if (l !== LR_EXP) $display("FAIL lj_lr got %h want %h", l, LR_EXP); else n_pass++;
    n_total++; if (low !== 128) $display("FAIL lj_lr_low_cycles got %0d want 128", low); else n_pass++;
    n_total++; if (starved !== 1'b0) $display("FAIL lj_starved got %b want 0", starved); else n_pass++;
    enable = 1'b0;
    @(negedge clk);
    n_total++; if ({i2s_bclk, i2s_lr, i2s_data} !== 3'b000) $display("FAIL lj_disable_out got %b want 000", {i2s_bclk, i2s_lr, i2s_data}); else n_pass++;
    n_total++; if (fifo_count !== 4'd0) $display("FAIL lj_count_after got %0d want 0", fifo_count); else n_pass++;
  endtask

  task automatic test_i2s_underrun;
    logic [63:0] d, l, exp2; int low; bit ok;
    push(24'hA5A5A5, 24'h3C3C3C);
    mode = 1'b0; enable = 1'b1;
    capture(d, l, low, ok);
    n_total++; if (!ok) $display("FAIL i2s_timeout got no frame want 64 bclk rises"); else n_pass++;
    n_total++; if (d !== {1'b0, fr(24'hA5A5A5, 24'h3C3C3C) >> 1}) $display("FAIL i2s_data got %h want %h", d, {1'b0, fr(24'hA5A5A5, 24'h3C3C3C) >> 1}); else n_pass++;
    n_total++; if (l !== LR_EXP) $display("FAIL i2s_lr got %h want %h", l, LR_EXP); else n_pass++;
    capture(d, l, low, ok);
`ifdef I2S_STREAM_HOLD_LAST_EN
    exp2 = fr(24'hA5A5A5, 24'h3C3C3C) >> 1;
`else
    exp2 = 64'd0;
`endif
    n_total++; if (d !== exp2) $display("FAIL underrun_data got %h want %h", d, exp2); else n_pass++;
    n_total++; if (starved !== 1'b1) $display("FAIL underrun_starved got %b want 1", starved); else n_pass++;
    // Two clk edges remain before the next frame start.
    starved_clear = 1'b1;
    @(negedge clk);
    n_total++; if (starved !== 1'b0) $display("FAIL starved_clear got %b want 0", starved); else n_pass++;
    starved_clear = 1'b0;
    @(negedge clk);
    n_total++; if (starved !== 1'b1) $display("FAIL starved_reset_again got %b want 1", starved); else n_pass++;
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fifo_full;
    logic [63:0] d, l; int low; bit ok;
    mode = 1'b1;
    for (int i = 0; i < 8; i++) push(24'h100000 + 24'(i), 24'h200000 + 24'(i));
    n_total++; if (fifo_count !== 4'd8) $display("FAIL full_count got %0d want 8", fifo_count); else n_pass++;
    n_total++; if (frame_ready !== 1'b0) $display("FAIL full_ready got %b want 0", frame_ready); else n_pass++;
    push(24'hDEAD00, 24'hBEEF00);
    n_total++; if (fifo_count !== 4'd8) $display("FAIL full_ninth_push got %0d want 8", fifo_count); else n_pass++;
    enable = 1'b1;
    @(negedge clk);
    n_total++; if (fifo_count !== 4'd7) $display("FAIL full_pop_count got %0d want 7", fifo_count); else n_pass++;
    n_total++; if (frame_ready !== 1'b1) $display("FAIL full_pop_ready got %b want 1", frame_ready); else n_pass++;
    capture(d, l, low, ok);
    n_total++; if (d !== fr(24'h100000, 24'h200000)) $display("FAIL full_first_frame got %h want %h", d, fr(24'h100000, 24'h200000)); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    logic [63:0] d, l; int low; bit ok; int c;
    c = 0;
    while (i2s_lr !== 1'b0 && c < 1000) begin @(negedge clk); c++; end
    while (i2s_lr !== 1'b1 && c < 1000) begin @(negedge clk); c++; end
    n_total++; if (c >= 1000) $display("FAIL mid_wait_right_slot got timeout want lr=1"); else n_pass++;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++; if ({i2s_bclk, i2s_lr, i2s_data} !== 3'b000) $display("FAIL mid_reset_out got %b want 000", {i2s_bclk, i2s_lr, i2s_data}); else n_pass++;
    n_total++; if (fifo_count !== 4'd0) $display("FAIL mid_reset_count got %0d want 0", fifo_count); else n_pass++;
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    push(24'h123456, 24'h654321);
    enable = 1'b1;
    capture(d, l, low, ok);
    n_total++; if (d !== fr(24'h123456, 24'h654321)) $display("FAIL mid_restart_data got %h want %h", d, fr(24'h123456, 24'h654321)); else n_pass++;
    n_total++; if (l !== LR_EXP) $display("FAIL mid_restart_lr got %h want %h", l, LR_EXP); else n_pass++;
    n_total++; if (low !== 128) $display("FAIL mid_restart_low got %0d want 128", low); else n_pass++;
    n_total++; if (starved !== 1'b0) $display("FAIL mid_restart_starved got %b want 0", starved); else n_pass++;
    enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_left_justified;
    test_i2s_underrun;
    test_fifo_full;
    test_reset_mid_frame;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/i2s_stream_writer.md
# i2s_stream_writer

- Parametrised single-clock I2S transmitter; next generation of the audio output path in the wb_i2s slave.
- Buffers stereo frames in an internal FIFO, generates bit clock and word select from `clk`, and serialises configurable-width samples MSB-first.
- Supports I2S and left-justified framing.
- Sits between the memory/DMA controller and the physical codec pins.

## Interface
- `SAMPLE_WIDTH`, 24: bits per channel sample, 8..SLOT_WIDTH.
- `SLOT_WIDTH`, 32: bit clocks per channel slot, ≥ SAMPLE_WIDTH.
- `FIFO_DEPTH`, 8: frame FIFO entries, power of two, ≥ 2.
- `CLK_DIV`, 4: `clk` cycles per bit-clock half period, ≥ 1.
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-low.
- `enable` in 1: run serialiser.
- `mode` in 1: 0 = I2S (one-bit delay), 1 = left-justified.
- `frame_valid` in 1: push request.
- `frame_ready` out 1: FIFO not full.
- `frame_left` in SAMPLE_WIDTH: left sample.
- `frame_right` in SAMPLE_WIDTH: right sample.
- `fifo_count` out $clog2(FIFO_DEPTH+1): occupied entries.
- `starved` out 1: sticky underrun flag.
- `starved_clear` in 1: clears `starved`.
- `i2s_bclk` out 1: bit clock.
- `i2s_lr` out 1: word select, 0 = left.
- `i2s_data` out 1: serial data.

## Operation
- Reset (`rst`=0 at a `clk` edge): FIFO empty, `fifo_count`=0, `frame_ready`=1, `starved`=0, `i2s_bclk`=0, `i2s_lr`=0, `i2s_data`=0, divider/bit counters cleared. Reset mid-frame aborts the frame; no partial output follows.
- Push: `frame_valid && frame_ready` stores {left,right}. Pushes are accepted regardless of `enable`.
- `enable`=0: bclk/lr/data held 0; counters cleared; FIFO contents retained.
- States: IDLE (disabled) → RUN. Within RUN, a bit counter runs 0..2*SLOT_WIDTH-1. Positions 0..SLOT_WIDTH-1 are the left slot (lr=0); the rest are the right slot (lr=1).
- Frame start (entering RUN, or bit counter wrap):
  - FIFO non-empty: pop into the frame shifter.
  - FIFO empty: set `starved`; transmit an underrun frame (see Configuration).
  - `mode` is sampled only here.
- Slot content: SAMPLE_WIDTH sample bits MSB-first, then SLOT_WIDTH-SAMPLE_WIDTH zeros.
- Left-justified: data bit k of the frame stream is driven at bit position k.
- I2S: stream bit k-1 is driven at position k. Position 0 carries the final stream bit of the previous frame, or 0 after entering RUN.
- `starved_clear` and a new underrun in the same cycle: `starved`=1 (set wins).
- Push and pop in the same cycle: `fifo_count` unchanged. When full, `frame_ready`=0, so no push occurs; the pop raises `frame_ready` next cycle.

## Timing
- Bit period = 2*CLK_DIV `clk` cycles. Frame = 4*SLOT_WIDTH*CLK_DIV cycles.
- The first `clk` edge with `enable`=1 is frame start. `i2s_lr`/`i2s_data` for position 0 are registered at that edge; `i2s_bclk` stays 0.
- `i2s_bclk` rises CLK_DIV cycles after each bit boundary and falls 2*CLK_DIV cycles after it. Each falling edge is the next bit boundary: `i2s_lr`/`i2s_data` update on the same `clk` edge that drives bclk low. Data is therefore stable around bclk rising.
- Pop occurs on the frame-start edge. `fifo_count` and `frame_ready` reflect it one cycle later.
- `enable` deasserted: outputs go to 0 on the next edge; a partial frame is discarded (its FIFO entry is already consumed).

## Configuration
- `I2S_STREAM_HOLD_LAST_EN` defined: an underrun frame retransmits the last successfully popped frame (zeros if none since reset).
- Not defined: an underrun frame is all zeros.
- `starved` sets identically in both cases.

## Test plan
- Reset: hold `rst`=0 with `enable`=1 and valid frames pushed → all outputs 0, `fifo_count`=0, `frame_ready`=1.
- Left-justified, CLK_DIV=2, SLOT 32, SAMPLE 24: push L=0xA5A5A5, R=0x3C3C3C, enable → lr low for 128 clk then high for 128 clk; data captured on bclk rise = 0xA5A5A5 followed by 8 zeros, then 0x3C3C3C followed by 8 zeros.
- I2S mode, same frame → identical bits shifted one bclk later relative to lr edges; first bit of frame 1 = 0.
- Underrun: push one frame, enable → second frame is zeros (or repeats the first with HOLD_LAST_EN); `starved`=1 from that frame start; `starved_clear` pulse → 0; next underrun sets it again.
- FIFO full, FIFO_DEPTH=8: 8 pushes while disabled → `fifo_count`=8, `frame_ready`=0; 9th `frame_valid` not accepted; enable → count 7, ready 1 one cycle after first pop.
- Reset asserted mid-right-slot → outputs 0 next edge; after release and re-push, the next frame starts cleanly at position 0 with lr=0.
